// File: rtl/hack_ram_pkg.sv
// Shared types and constants for the Hack RAM slices (RAM8 and up).
package hack_ram_pkg;

  localparam int WORD_W      = 16;
  localparam int RAM8_DEPTH  = 8;
  localparam int RAM8_ADDR_W = 3;

  typedef logic [WORD_W-1:0]                  word_t;
  typedef logic [RAM8_ADDR_W-1:0]             addr3_t;
  typedef logic [RAM8_DEPTH-1:0][WORD_W-1:0]  bank8_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram8_wr_state_t;

endpackage

// File: rtl/ram8_write_bank_dmux8.sv
// 1-to-8 demux of a single enable onto a one-hot bus; reused by wider RAM write paths.
module dmux8_1_bit
  import hack_ram_pkg::*;
(
  input  logic       en,
  input  addr3_t     sel,
  output logic [7:0] out
);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign out[gi] = en && (sel == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/ram8_write_bank.sv
// Write side of the 8-word RAM slice: handshake write port, dirty flags and a
// one-word-per-cycle clear sweep; all words exposed for the external read mux.
module ram8_write_bank
  import hack_ram_pkg::*;
#(
  parameter int WORD_W = hack_ram_pkg::WORD_W,
  parameter int DEPTH  = hack_ram_pkg::RAM8_DEPTH,
  parameter int ADDR_W = hack_ram_pkg::RAM8_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [WORD_W-1:0]             wr_data,
  input  logic                          clr_start,
  output logic                          busy,
  output logic [DEPTH-1:0]              dirty,
  output logic [DEPTH-1:0]              load_onehot,
  output logic [DEPTH-1:0][WORD_W-1:0]  words_out
);

  ram8_wr_state_t               state_q, state_d;
  logic [ADDR_W-1:0]            clr_idx_q, clr_idx_d;
  logic [DEPTH-1:0]             dirty_q, dirty_d;
  logic [DEPTH-1:0][WORD_W-1:0] words_q, words_d;
  logic                         wr_accept;

  // Ready is masked during reset so no load pulse escapes while the bank is held.
  assign wr_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q == CLEAR);
  assign wr_accept = wr_valid && wr_ready;

  dmux8_1_bit u_dmux (
    .en  (wr_accept),
    .sel (wr_addr),
    .out (load_onehot)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    dirty_d   = dirty_q;
    words_d   = words_q;
    case (state_q)
      IDLE: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (load_onehot[i]) begin
            words_d[i] = wr_data;
            dirty_d[i] = 1'b1;
          end
        end
        if (clr_start) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        words_d[clr_idx_q] = '0;
        dirty_d[clr_idx_q] = 1'b0;
        clr_idx_d          = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      dirty_q   <= '0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      dirty_q   <= dirty_d;
      words_q   <= words_d;
    end
  end

  assign dirty     = dirty_q;
  assign words_out = words_q;

endmodule

// File: tb/tb_ram8_write_bank.sv
// Directed bench for ram8_write_bank: inputs driven and outputs sampled on the falling edge.
module tb_ram8_write_bank;
  import hack_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clr_start;
  logic        busy;
  logic [7:0]  dirty;
  logic [7:0]  load_onehot;
  bank8_t      words_out;

  int checks = 0;
  int errors = 0;
  bank8_t exp_bank;

  always #5 clk = ~clk;

  ram8_write_bank dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clr_start   (clr_start),
    .busy        (busy),
    .dirty       (dirty),
    .load_onehot (load_onehot),
    .words_out   (words_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'hFFFF; clr_start = 1'b0;
    exp_bank = '0;

    // Reset held for two edges; no load may escape while reset is high.
    @(negedge clk);
    #1 chk("onehot_in_reset", 128'(load_onehot), 128'h00);
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    #1;
    chk("reset_words", 128'(words_out), 128'(exp_bank));
    chk("reset_dirty", 128'(dirty), 128'h00);
    chk("reset_ready", 128'(wr_ready), 128'h1);
    chk("reset_busy", 128'(busy), 128'h0);

    // Single write, address 5.
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
    #1;
    chk("single_onehot", 128'(load_onehot), 128'h20);
    chk("single_no_bypass", 128'(words_out[5]), 128'h0000);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    exp_bank[5] = 16'hBEEF;
    chk("single_words", 128'(words_out), 128'(exp_bank));
    chk("single_dirty", 128'(dirty), 128'h20);

    // Burst fill, one write per cycle.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 16'h1000 + 16'(i);
      #1 chk($sformatf("burst_ready_%0d", i), 128'(wr_ready), 128'h1);
      @(negedge clk);
      #1 chk($sformatf("burst_word_%0d", i), 128'(words_out[i]), 128'(16'h1000 + 16'(i)));
      exp_bank[i] = 16'h1000 + 16'(i);
    end
    wr_valid = 1'b0;
    chk("burst_words", 128'(words_out), 128'(exp_bank));
    chk("burst_dirty", 128'(dirty), 128'hFF);

    // Clear sweep with a write to address 2 held throughout; a second clr_start mid-sweep is ignored.
    clr_start = 1'b1;
    #1 chk("clr_start_busy_not_yet", 128'(busy), 128'h0);
    @(negedge clk);
    clr_start = 1'b0; wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      clr_start = (k == 3);
      #1;
      chk($sformatf("clr_busy_%0d", k), 128'(busy), 128'h1);
      chk($sformatf("clr_ready_%0d", k), 128'(wr_ready), 128'h0);
      chk($sformatf("clr_onehot_%0d", k), 128'(load_onehot), 128'h00);
      @(negedge clk);
      #1;
      exp_bank[k] = 16'h0000;
      chk($sformatf("clr_order_%0d", k), 128'(words_out), 128'(exp_bank));
    end
    clr_start = 1'b0;
    chk("clr_done_busy", 128'(busy), 128'h0);
    chk("clr_done_ready", 128'(wr_ready), 128'h1);
    chk("clr_done_dirty", 128'(dirty), 128'h00);
    chk("held_write_onehot", 128'(load_onehot), 128'h04);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    exp_bank[2] = 16'h1234;
    chk("held_write_words", 128'(words_out), 128'(exp_bank));
    chk("held_write_dirty", 128'(dirty), 128'h04);

    // Write and clr_start in the same IDLE cycle.
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hAAAA; clr_start = 1'b1;
    #1 chk("simul_onehot", 128'(load_onehot), 128'h08);
    @(negedge clk);
    wr_valid = 1'b0; clr_start = 1'b0;
    #1;
    chk("simul_committed", 128'(words_out[3]), 128'hAAAA);
    chk("simul_dirty", 128'(dirty), 128'h0C);
    chk("simul_busy1", 128'(busy), 128'h1);
    repeat (7) @(negedge clk);
    #1 chk("simul_busy8", 128'(busy), 128'h1);
    @(negedge clk);
    #1;
    exp_bank = '0;
    chk("simul_busy_end", 128'(busy), 128'h0);
    chk("simul_words", 128'(words_out), 128'(exp_bank));
    chk("simul_dirty_end", 128'(dirty), 128'h00);

    // Reset in the middle of a clear sweep.
    wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
    @(negedge clk);
    wr_valid = 1'b0; clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midclr_busy4", 128'(busy), 128'h1);
    chk("midclr_word6_pending", 128'(words_out[6]), 128'h6666);
    chk("midclr_dirty_pending", 128'(dirty), 128'h40);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midclr_busy", 128'(busy), 128'h0);
    chk("midclr_ready", 128'(wr_ready), 128'h1);
    chk("midclr_words", 128'(words_out), 128'(exp_bank));
    chk("midclr_dirty", 128'(dirty), 128'h00);
    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 16'h5555;
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    exp_bank[7] = 16'h5555;
    chk("post_reset_words", 128'(words_out), 128'(exp_bank));
    chk("post_reset_dirty", 128'(dirty), 128'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram8_write_bank.md
Name: ram8_write_bank

Overview:
- Write side of the 8-word RAM slice: decodes a 3-bit write address into a one-hot load and stores 16-bit words in an 8-entry register bank.
- Exposes all 8 words as a packed [7:0][15:0] bus that feeds the existing 8:1 read mux directly.
- Adds a valid/ready write handshake, per-word dirty flags and a sequential clear engine that zeroes the bank one word per cycle.

Parameters:
- WORD_W, 16, data width of each stored word.
- DEPTH, 8, number of words; fixed at 8 for this slice.
- ADDR_W, 3, address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  bank can accept a write this cycle.
- wr_addr  input  3  target word index.
- wr_data  input  16  word to store.
- clr_start  input  1  one-cycle request to zero the whole bank.
- busy  output  1  clear sequence in progress.
- dirty  output  8  bit i set when word i has been written since the last reset or clear.
- load_onehot  output  8  combinational decode of the accepted write; bit wr_addr high only when wr_valid && wr_ready.
- words_out  output  [7:0][15:0]  registered contents of all 8 words, packed for the read mux.

Behaviour:
- Reset: synchronous, active-high, checked at the rising edge of clk. Clears words_out[all] to 0, dirty to 0, busy to 0 and clr_idx to 0; state goes to IDLE and wr_ready is 1 after that edge.
- States:
  - IDLE: wr_ready=1, busy=0.
  - CLEAR: wr_ready=0, busy=1.
- Write handshake: a write is accepted on any edge where wr_valid && wr_ready.
  - On that edge, words[wr_addr] <= wr_data and dirty[wr_addr] <= 1.
  - The new value appears on words_out the cycle after the accepting edge; latency is 1.
  - There is no bypass: same-cycle readback returns the old value.
- Back-to-back writes: one write per cycle is supported with no bubbles. Consecutive writes to the same address leave the last value written.
- wr_valid while wr_ready=0: no effect and no queuing. The requester must hold its request until ready is high.
- IDLE -> CLEAR: on clr_start=1, clr_idx <= 0.
- CLEAR, each cycle:
  - words[clr_idx] <= 0 and dirty[clr_idx] <= 0, then clr_idx increments.
  - On the edge that clears index 7, state returns to IDLE.
  - The sequence takes exactly 8 cycles with busy high; wr_ready is high again in the 9th cycle after clr_start.
- clr_idx: 3 bits, wraps 7->0 naturally. It is not used for the exit condition beyond the compare with 7.
- clr_start and an accepted write in the same IDLE cycle: the write commits on that edge and CLEAR starts. The written word is later zeroed by the sweep, so the final state is all zero and dirty=0.
- clr_start during CLEAR: ignored; the sequence does not restart.
- Reset mid-clear: returns to IDLE with the whole bank zero on the next edge, whatever clr_idx was.
- Out-of-range addresses: none exist, since DEPTH equals 2^ADDR_W.
- load_onehot: all zero whenever no write is accepted, including during CLEAR and during reset.

Decomposition:
- Package hack_ram_pkg holds:
  - constants WORD_W=16, RAM8_DEPTH=8, RAM8_ADDR_W=3;
  - typedefs word_t (logic [15:0]), addr3_t (logic [2:0]) and bank8_t (logic [7:0][15:0]);
  - enum ram8_wr_state_t {IDLE, CLEAR}.
- Sub-module dmux8_1_bit: combinational 1-to-8 demux of an enable onto a one-hot bus selected by a 3-bit address. It produces load_onehot and is reusable by RAM64/RAM512 write paths.
- ram8_write_bank contains the FSM, clear counter, dirty register and storage.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> words_out all 0x0000, dirty=0x00, wr_ready=1, busy=0.
- Single write: write addr=5, data=0xBEEF -> load_onehot=0x20 in the accepting cycle; next cycle words_out[5]=0xBEEF, dirty=0x20, other words 0.
- Burst fill: write addr 0..7 with data 0x1000+i on 8 consecutive cycles -> each word equals 0x1000+i one cycle after its write, dirty=0xFF, wr_ready never drops.
- Clear sequence: after the burst fill, pulse clr_start -> busy=1 and wr_ready=0 for exactly 8 cycles, words zero in index order 0..7, dirty=0x00 at the end. A wr_valid (addr=2, 0x1234) held during the sweep is not accepted until wr_ready returns, then words_out[2]=0x1234.
- Simultaneous write and clear: in IDLE, write addr=3, 0xAAAA with clr_start=1 in the same cycle -> write commits; after 8 busy cycles words_out[3]=0x0000, dirty=0x00.
- Reset mid-clear: pulse clr_start, assert rst at busy cycle 4 -> next cycle state IDLE, busy=0, all words 0, wr_ready=1; a following write to addr=7, 0x5555 lands normally.
